// File: rtl/button_sync_debounce.sv
// Push-button conditioner: 2-flop synchroniser, press/release debounce, one-cycle press pulse.
// Optional auto-repeat while held is compiled in with `define BUTTON_REPEAT_EN.
module button_sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20,
    parameter int REPEAT_CYCLES   = 8
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       BI,
    output logic       BO,
    output logic       Held,
    output logic [7:0] PressCount,
    output logic [2:0] dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_PULSE  = 3'd2,
        ST_HELD   = 3'd3,
        ST_DISARM = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (CNT_W < 32 && (DEBOUNCE_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES-1");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be >= 1");
    end

    logic             s1_q;
    logic             s2_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bo_q;
    logic             held_q;
    logic [7:0]       press_cnt_q;

`ifdef BUTTON_REPEAT_EN
    localparam int RCNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_CYCLES - 1);
    logic [RCNT_W-1:0] rcnt_q;
`endif

    // bo_q/held_q are loaded with the value implied by the state being entered,
    // so they always equal the Moore decode of state_q without a decode glitch.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bo_q        <= 1'b0;
            held_q      <= 1'b0;
            press_cnt_q <= 8'd0;
`ifdef BUTTON_REPEAT_EN
            rcnt_q      <= '0;
`endif
        end else begin
            s1_q <= BI;
            s2_q <= s1_q;
            bo_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (s2_q) begin
                        state_q <= ST_ARM;
                        cnt_q   <= '0;
                    end
                end
                ST_ARM: begin
                    if (!s2_q) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_PULSE;
                        bo_q    <= 1'b1;
                        held_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_PULSE: begin
                    state_q     <= ST_HELD;
                    press_cnt_q <= press_cnt_q + 8'd1;
`ifdef BUTTON_REPEAT_EN
                    rcnt_q      <= '0;
`endif
                end
                ST_HELD: begin
                    if (!s2_q) begin
                        state_q <= ST_DISARM;
                        cnt_q   <= '0;
                    end
`ifdef BUTTON_REPEAT_EN
                    else if (rcnt_q == RCNT_LAST) begin
                        state_q <= ST_PULSE;
                        bo_q    <= 1'b1;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
`endif
                end
                ST_DISARM: begin
                    if (s2_q) begin
                        state_q <= ST_HELD;
`ifdef BUTTON_REPEAT_EN
                        rcnt_q  <= '0;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_IDLE;
                        held_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    held_q  <= 1'b0;
                end
            endcase
        end
    end

    assign BO          = bo_q;
    assign Held        = held_q;
    assign PressCount  = press_cnt_q;
    assign dbg_state_o = state_q;

endmodule
